// File: rtl/arch_map_retire.sv
// Retire-side architectural map for R10K-style renaming: commits T of each retiring
// instruction and emits a dense list of displaced T_old registers for the free list.
module arch_map_retire #(
    parameter int unsigned N         = 4,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned ARCH_BITS = $clog2(ARCH_REGS),
    parameter int unsigned PHYS_BITS = 6,
    parameter int unsigned NUM_BITS  = $clog2(N + 1)
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_BITS-1:0]                   num_retiring,
    input  logic [N-1:0]                          ret_has_dest,
    input  logic [N-1:0][ARCH_BITS-1:0]           ret_arch_dest,
    input  logic [N-1:0][PHYS_BITS-1:0]           ret_T,
    input  logic [N-1:0][PHYS_BITS-1:0]           ret_T_old,
    output logic [N-1:0][PHYS_BITS-1:0]           freed_regs,
    output logic [NUM_BITS-1:0]                   num_freed,
    output logic [ARCH_REGS-1:0][PHYS_BITS-1:0]   arch_map
);

    localparam int unsigned IDX_BITS = (N > 1) ? $clog2(N) : 1;
    localparam logic [NUM_BITS-1:0] N_CNT = NUM_BITS'(N);

    logic [NUM_BITS-1:0]                 n_eff;
    logic [NUM_BITS-1:0]                 cnt_next;
    logic [N-1:0][PHYS_BITS-1:0]         free_next;
    logic [ARCH_REGS-1:0][PHYS_BITS-1:0] map_next;

    // Walk slots in order: later same-destination slots overwrite earlier ones,
    // and every active slot appends its T_old to the packed free list.
    always_comb begin
        n_eff     = (num_retiring > N_CNT) ? N_CNT : num_retiring;
        map_next  = arch_map;
        free_next = '0;
        cnt_next  = '0;
        for (int k = 0; k < N; k++) begin
            if ((NUM_BITS'(k) < n_eff) && ret_has_dest[k] && (ret_arch_dest[k] != '0)) begin
                map_next[ret_arch_dest[k]]     = ret_T[k];
                free_next[IDX_BITS'(cnt_next)] = ret_T_old[k];
                cnt_next                       = cnt_next + NUM_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                arch_map[i] <= PHYS_BITS'(i);
            end
            freed_regs <= '0;
            num_freed  <= '0;
        end else begin
            arch_map   <= map_next;
            freed_regs <= free_next;
            num_freed  <= cnt_next;
        end
    end

    a_num_retiring_legal: assert property (@(posedge clock) disable iff (reset)
        num_retiring <= N_CNT)
        else $error("arch_map_retire: num_retiring %0d exceeds retire width %0d", num_retiring, N);

endmodule

// File: tb/tb_arch_map_retire.sv
// Scoreboard bench for arch_map_retire: directed retire bundles with hand-computed
// expectations queued at issue and checked by an independent monitor.
module tb_arch_map_retire;

    localparam int unsigned N         = 4;
    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned AB        = 5;
    localparam int unsigned PB        = 6;
    localparam int unsigned NB        = 3;

    typedef struct packed {
        logic [NB-1:0]                 num;
        logic [N-1:0][PB-1:0]          freed;
        logic [ARCH_REGS-1:0][PB-1:0]  map;
    } exp_t;

    logic                          clock;
    logic                          reset;
    logic [NB-1:0]                 num_retiring;
    logic [N-1:0]                  ret_has_dest;
    logic [N-1:0][AB-1:0]          ret_arch_dest;
    logic [N-1:0][PB-1:0]          ret_T;
    logic [N-1:0][PB-1:0]          ret_T_old;
    logic [N-1:0][PB-1:0]          freed_regs;
    logic [NB-1:0]                 num_freed;
    logic [ARCH_REGS-1:0][PB-1:0]  arch_map;

    logic [N-1:0]                  s_hd;
    logic [N-1:0][AB-1:0]          s_dest;
    logic [N-1:0][PB-1:0]          s_t;
    logic [N-1:0][PB-1:0]          s_told;
    logic [ARCH_REGS-1:0][PB-1:0]  gmap;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    arch_map_retire #(.N(N), .ARCH_REGS(ARCH_REGS), .PHYS_BITS(PB)) dut (
        .clock         (clock),
        .reset         (reset),
        .num_retiring  (num_retiring),
        .ret_has_dest  (ret_has_dest),
        .ret_arch_dest (ret_arch_dest),
        .ret_T         (ret_T),
        .ret_T_old     (ret_T_old),
        .freed_regs    (freed_regs),
        .num_freed     (num_freed),
        .arch_map      (arch_map)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    // Monitor: outputs are presented every cycle; pop one expectation per edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("num_freed",  256'(num_freed),  256'(e.num));
            check("freed_regs", 256'(freed_regs), 256'(e.freed));
            check("arch_map",   256'(arch_map),   256'(e.map));
        end
    end

    task automatic clear_slots();
        s_hd = '0; s_dest = '0; s_t = '0; s_told = '0;
    endtask

    task automatic set_slot(input int k, input logic hd, input int d, input int t, input int told);
        s_hd[k]   = hd;
        s_dest[k] = AB'(d);
        s_t[k]    = PB'(t);
        s_told[k] = PB'(told);
    endtask

    task automatic gmap_identity();
        for (int i = 0; i < ARCH_REGS; i++) gmap[i] = PB'(i);
    endtask

    // Apply one cycle of stimulus and queue the hand-computed expected response.
    task automatic step(input logic rst, input int nr, input int en,
                        input int f0, input int f1, input int f2, input int f3);
        exp_t e;
        @(negedge clock);
        reset         = rst;
        num_retiring  = NB'(nr);
        ret_has_dest  = s_hd;
        ret_arch_dest = s_dest;
        ret_T         = s_t;
        ret_T_old     = s_told;
        e.num      = NB'(en);
        e.freed[0] = PB'(f0);
        e.freed[1] = PB'(f1);
        e.freed[2] = PB'(f2);
        e.freed[3] = PB'(f3);
        e.map      = gmap;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        num_retiring = '0; ret_has_dest = '0; ret_arch_dest = '0; ret_T = '0; ret_T_old = '0;
        clear_slots();
        gmap_identity();

        // Reset held two cycles
        step(1'b1, 0, 0, 0, 0, 0, 0);
        step(1'b1, 0, 0, 0, 0, 0, 0);

        // Single retire
        set_slot(0, 1'b1, 3, 40, 3);
        gmap[3] = PB'(40);
        step(1'b0, 1, 1, 3, 0, 0, 0);

        // Slot 0 has no dest, slot 1 packs into position 0
        clear_slots();
        set_slot(0, 1'b0, 4, 50, 4);
        set_slot(1, 1'b1, 5, 41, 5);
        gmap[5] = PB'(41);
        step(1'b0, 2, 1, 5, 0, 0, 0);

        // Same destination twice: later slot wins, both T_old freed
        clear_slots();
        set_slot(0, 1'b1, 7, 42, 7);
        set_slot(1, 1'b1, 7, 43, 42);
        gmap[7] = PB'(43);
        step(1'b0, 2, 2, 7, 42, 0, 0);

        // Destination r0 never retires
        clear_slots();
        set_slot(0, 1'b1, 0, 44, 9);
        step(1'b0, 1, 0, 0, 0, 0, 0);

        // Slots beyond num_retiring ignored
        clear_slots();
        set_slot(0, 1'b1, 10, 45, 10);
        set_slot(1, 1'b1, 11, 46, 11);
        set_slot(2, 1'b1, 15, 47, 15);
        set_slot(3, 1'b1, 16, 48, 16);
        gmap[10] = PB'(45);
        step(1'b0, 1, 1, 10, 0, 0, 0);
        step(1'b0, 0, 0, 0, 0, 0, 0);

        // Full bundle with a hole at slot 2 (dest r0)
        clear_slots();
        set_slot(0, 1'b1, 12, 50, 12);
        set_slot(1, 1'b1, 13, 51, 13);
        set_slot(2, 1'b1, 0, 52, 30);
        set_slot(3, 1'b1, 14, 53, 14);
        gmap[12] = PB'(50);
        gmap[13] = PB'(51);
        gmap[14] = PB'(53);
        step(1'b0, 4, 3, 12, 13, 14, 0);

        // Four distinct active slots fill the list
        clear_slots();
        set_slot(0, 1'b1, 1, 33, 1);
        set_slot(1, 1'b1, 2, 34, 2);
        set_slot(2, 1'b1, 3, 35, 40);
        set_slot(3, 1'b1, 31, 36, 31);
        gmap[1] = PB'(33); gmap[2] = PB'(34); gmap[3] = PB'(35); gmap[31] = PB'(36);
        step(1'b0, 4, 4, 1, 2, 40, 31);

        // Reset wins over a full active bundle
        clear_slots();
        set_slot(0, 1'b1, 20, 60, 20);
        set_slot(1, 1'b1, 21, 61, 21);
        set_slot(2, 1'b1, 22, 62, 22);
        set_slot(3, 1'b1, 23, 63, 23);
        gmap_identity();
        step(1'b1, 4, 0, 0, 0, 0, 0);

        // Idle after reset
        clear_slots();
        step(1'b0, 0, 0, 0, 0, 0, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
        @(negedge clock);
        check("scoreboard_drained", 256'(exp_q.size()), 256'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
